fetch_stage: RTL

Instruction-fetch stage of the 16-bit pipelined core. It owns the PC and the IF/ID pipeline register, and drives the instruction-memory address. It consumes the PC-stall request from the hazard controller and the branch redirect from the execute stage, and feeds the IF/ID instruction consumed by decode and by the hazard controller. It also detects a HALT instruction and freezes fetch.

---
 rtl/fetch_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the 16-bit pipelined core. Owns the PC and the
// IF/ID pipeline register, drives the instruction-memory address, honours
// the hazard controller's PC stall and the execute stage's branch redirect,
// and freezes fetch when a HALT instruction is latched.
//
// Configuration macro: FETCH_PERF_EN
//   defined   -> saturating stall_cycles / flush_count performance counters
//   undefined -> both counter ports are tied to zero
//
// Ports:
//   clock          in   1   rising-edge clock
//   reset          in   1   synchronous active-high reset
//   pc_stall       in   1   hold PC and IF/ID (hazard controller)
//   branch_taken   in   1   redirect request from execute
//   branch_target  in  16   redirect PC
//   imem_addr      out 16   instruction-memory word address (= PC)
//   imem_data      in  16   instruction word, valid in the same cycle
//   ifid_instr     out 16   IF/ID instruction
//   ifid_pc1       out 16   IF/ID PC+1 of that instruction
//   ifid_valid     out  1   IF/ID holds a real instruction
//   halted         out  1   fetch frozen on HALT
//   stall_cycles   out 16   perf counter: stalled RUN cycles
//   flush_count    out 16   perf counter: redirects taken
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc1,
  output logic        ifid_valid,
  output logic        halted,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [15:0] r_pc;
  logic [15:0] r_ifidInstr;
  logic [15:0] r_ifidPc1;
  logic        r_ifidValid;

  logic [15:0] w_nextPc;
  logic [15:0] w_nextIfidInstr;
  logic [15:0] w_nextIfidPc1;
  logic        w_nextIfidValid;
  logic [15:0] w_pcPlus1;

  // Wraps modulo 2^16 naturally through the 16-bit result width.
  assign w_pcPlus1 = r_pc + 16'd1;

  // State and pipeline registers; all next values come from the
  // combinational block below.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= BOOT;
      r_pc        <= RESET_PC;
      r_ifidInstr <= NOP_INSTR;
      r_ifidPc1   <= 16'h0000;
      r_ifidValid <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_pc        <= w_nextPc;
      r_ifidInstr <= w_nextIfidInstr;
      r_ifidPc1   <= w_nextIfidPc1;
      r_ifidValid <= w_nextIfidValid;
    end
  end

  // Next-state and datapath selection. Everything holds by default; a
  // redirect outranks a stall, and a stall outranks a normal advance.
  // BOOT ignores both requests so the hazard controller's reset-held
  // stall cannot leak into the first real fetch.
  always_comb begin
    w_nextState     = r_state;
    w_nextPc        = r_pc;
    w_nextIfidInstr = r_ifidInstr;
    w_nextIfidPc1   = r_ifidPc1;
    w_nextIfidValid = r_ifidValid;

    case (r_state)
      BOOT: begin
        w_nextState = RUN;
      end

      RUN: begin
        if (branch_taken) begin
          w_nextPc        = branch_target;
          w_nextIfidInstr = NOP_INSTR;
          w_nextIfidPc1   = 16'h0000;
          w_nextIfidValid = 1'b0;
        end else if (!pc_stall) begin
          w_nextIfidInstr = imem_data;
          w_nextIfidPc1   = w_pcPlus1;
          w_nextIfidValid = 1'b1;
          // A HALT is latched like any instruction but the PC parks on it.
          if (imem_data == HALT_INSTR) begin
            w_nextState = HALTED;
          end else begin
            w_nextPc = w_pcPlus1;
          end
        end
      end

      HALTED: begin
        if (branch_taken) begin
          // The HALT was on a wrong path behind an older branch.
          w_nextState     = RUN;
          w_nextPc        = branch_target;
          w_nextIfidInstr = NOP_INSTR;
          w_nextIfidPc1   = 16'h0000;
          w_nextIfidValid = 1'b0;
        end else if (!pc_stall) begin
          // Once decode has taken the HALT, drain bubbles behind it.
          w_nextIfidInstr = NOP_INSTR;
          w_nextIfidPc1   = 16'h0000;
          w_nextIfidValid = 1'b0;
        end
      end

      default: begin
        w_nextState = BOOT;
      end
    endcase
  end

  assign imem_addr  = r_pc;
  assign ifid_instr = r_ifidInstr;
  assign ifid_pc1   = r_ifidPc1;
  assign ifid_valid = r_ifidValid;
  assign halted     = (r_state == HALTED);

`ifdef FETCH_PERF_EN
  logic [15:0] r_stallCycles;
  logic [15:0] r_flushCount;

  // Saturating performance counters. Stalls are counted only in RUN and
  // only when no redirect overrides them; redirects count in RUN and HALTED.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stallCycles <= 16'h0000;
      r_flushCount  <= 16'h0000;
    end else begin
      if ((r_state == RUN) && pc_stall && !branch_taken &&
          (r_stallCycles != 16'hFFFF)) begin
        r_stallCycles <= r_stallCycles + 16'd1;
      end
      if (((r_state == RUN) || (r_state == HALTED)) && branch_taken &&
          (r_flushCount != 16'hFFFF)) begin
        r_flushCount <= r_flushCount + 16'd1;
      end
    end
  end

  assign stall_cycles = r_stallCycles;
  assign flush_count  = r_flushCount;
`else
  assign stall_cycles = 16'h0000;
  assign flush_count  = 16'h0000;
`endif

endmodule
